stack_unit: RTL and testbench
=============================

# stack_unit

Parametrised hardware operand stack for the multicycle stack-machine datapath. Executes the controller's `push`, `pop` and `tos` strobes against a register-file stack of configurable width and depth. Gives a registered top-of-stack result, occupancy count, full/empty status and sticky overflow/underflow error flags. Sits between the controller and the ALU/memory datapath and replaces the fixed-size stack of the previous generation. Adds the combined push+pop (replace-top) operation and error reporting.

## Interface
- `DATA_W`, 8, word width of every stack entry.
- `DEPTH`, 8, number of entries; legal range is 2 or more.
- `CNT_W`, `$clog2(DEPTH+1)`, occupancy counter width (derived; not overridden).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  write `din` onto the stack this cycle.
- `pop`  in  1  remove the top entry and return it on `dout`.
- `tos`  in  1  copy the top entry to `dout` without removing it.
- `err_clr`  in  1  synchronous clear of `ovf`/`udf`.
- `din`  in  DATA_W  data to push.
- `dout`  out  DATA_W  registered result of the last successful `pop`/`tos`/replace.
- `count`  out  CNT_W  current number of valid entries, registered.
- `empty`  out  1  `count == 0`, combinational from `count`.
- `full`  out  1  `count == DEPTH`, combinational from `count`.
- `ovf`  out  1  sticky: a push was refused because the stack was full.
- `udf`  out  1  sticky: a pop, tos or replace was refused because the stack was empty.

## Operation
- Storage is a `DEPTH`-entry array. `count` is also the stack pointer: the next free slot is `mem[count]` and the top is `mem[count-1]`. Array contents are not reset.
- Command decode, evaluated at each rising edge, first match wins:
  - push & pop, not empty (replace): `dout <= mem[count-1]`; `mem[count-1] <= din`; `count` unchanged. `tos` is ignored.
  - push & pop, empty: treated as push only; `udf <= 1`.
  - push only, not full: `mem[count] <= din`; `count <= count+1`.
  - push only, full: no state change except `ovf <= 1`.
  - pop only, not empty: `dout <= mem[count-1]`; `count <= count-1`.
  - pop only, empty: no change except `udf <= 1`.
  - tos only, not empty: `dout <= mem[count-1]`.
  - tos only, empty: `dout` holds; `udf <= 1`.
  - `tos` together with push or pop: `tos` is ignored.
  - none asserted: hold everything.
- Replace on a full stack is legal, because occupancy does not change.
- `err_clr` clears `ovf` and `udf`. If an error occurs in the same cycle as `err_clr`, the set wins.
- `dout` changes only on a successful pop, tos or replace. Otherwise it holds its last value.
- `count` never exceeds `DEPTH` and never wraps below 0.

## Timing
- Reset values: `count=0`, `dout=0`, `ovf=0`, `udf=0`, so `empty=1` and `full=0`.
- Reset is asynchronous. Asserting `rst` mid-operation clears the stack logically at once and discards any in-flight command. The first command accepted is the one sampled at the first rising edge after `rst` deasserts.
- Latency is one cycle for every command. A pop or tos strobed in cycle N gives `dout` valid after edge N and for all of cycle N+1.
- Back-to-back commands are allowed every cycle; there is no busy state.
- A push in cycle N followed by a pop in cycle N+1 returns the pushed word.
- `full`, `empty`, `ovf` and `udf` reflect state after the edge and are valid in the same cycle as `count`.
- Commands are single-cycle strobes; holding a strobe high for k cycles repeats the command k times.

## Test plan
(All scenarios use `DATA_W=8`, `DEPTH=4`.)
- Reset: pulse `rst` with no clock edge in between, then idle → `count=0`, `empty=1`, `full=0`, `dout=0x00`, `ovf=0`, `udf=0`.
- Fill then overflow: push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles → after the 4th push `count=4`, `full=1`. After the 5th push `ovf=1`, `count=4`, and the top is still 0x44.
- LIFO order and underflow: from the full stack, pop 5 times → `dout` reads 0x44, 0x33, 0x22, 0x11 on successive cycles. After the 4th pop `empty=1`. After the 5th pop `udf=1` and `dout` holds 0x11.
- Tos and replace: push 0xA0, push 0xB0, tos → `dout=0xB0`, `count=2`. Then push+pop with `din=0xC0` → `dout=0xB0`, `count=2`. Then pop → `dout=0xC0`, `count=1`.
- Error priority: with `ovf=1` set, assert `err_clr` in the same cycle as a pop on an empty stack → `ovf=0` and `udf=1` after the edge.
- Mid-operation reset: push 0x5A, 0x6B, then assert `rst` asynchronously between clock edges → `count=0` and `dout=0x00` immediately, without waiting for an edge. After release, a pop gives `udf=1`.

Source files
------------

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_unit
// Summary  : Parametrised LIFO operand stack with push/pop/tos/replace and
//            sticky overflow/underflow reporting.
// Revision : 1.0
// ============================================================================
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  localparam int             c_addr_w = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [DATA_W-1:0]   r_dout;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;
  logic                r_udf;

  logic                w_empty;
  logic                w_full;
  logic [c_addr_w-1:0] w_wr_idx;
  logic [c_addr_w-1:0] w_top_idx;
  logic                w_do_replace;
  logic                w_do_push;
  logic                w_do_pop;
  logic                w_do_tos;
  logic                w_ovf_set;
  logic                w_udf_set;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // Low address bits suffice: the write slot is only used when not full, and
  // for power-of-two depths the modular decrement of a full count lands on
  // the last entry.
  assign w_wr_idx  = r_count[c_addr_w-1:0];
  assign w_top_idx = r_count[c_addr_w-1:0] - c_addr_w'(1);

  assign w_do_replace = push & pop & ~w_empty;
  assign w_do_push    = push & (~pop | w_empty) & ~w_full;
  assign w_do_pop     = pop & ~push & ~w_empty;
  assign w_do_tos     = tos & ~push & ~pop & ~w_empty;
  assign w_ovf_set    = push & ~pop & w_full;
  assign w_udf_set    = w_empty & (pop | (tos & ~push));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_do_replace || w_do_pop || w_do_tos) begin
        r_dout <= r_mem[w_top_idx];
      end
      // A new error in the same cycle as the clear takes precedence.
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
      r_udf <= w_udf_set | (r_udf & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_replace) begin
      r_mem[w_top_idx] <= din;
    end else if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  assign dout  = r_dout;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_unit
// Summary  : Directed plus random scoreboard bench for stack_unit (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_stack_unit;

  localparam int c_data_w = 8;
  localparam int c_depth  = 4;
  localparam int c_cnt_w  = $clog2(c_depth + 1);

  logic                clk;
  logic                rst;
  logic                push;
  logic                pop;
  logic                tos;
  logic                err_clr;
  logic [c_data_w-1:0] din;
  logic [c_data_w-1:0] dout;
  logic [c_cnt_w-1:0]  count;
  logic                empty;
  logic                full;
  logic                ovf;
  logic                udf;

  int checks = 0;
  int errors = 0;

  logic [7:0] stk[$];
  logic [7:0] sb[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;

  stack_unit #(.DATA_W(c_data_w), .DEPTH(c_depth)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
    .err_clr(err_clr), .din(din), .dout(dout), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("count", 32'(count), 32'(stk.size()));
    chk("empty", 32'(empty), 32'(stk.size() == 0));
    chk("full",  32'(full),  32'(stk.size() == c_depth));
    chk("ovf",   32'(ovf),   32'(m_ovf));
    chk("udf",   32'(udf),   32'(m_udf));
  endtask

  // Drives one command for one edge; expected dout goes to the scoreboard.
  task automatic cmd(input logic p, input logic q, input logic t, input logic c,
                     input logic [7:0] d);
    logic me, mf;
    push = p; pop = q; tos = t; err_clr = c; din = d;
    me = (stk.size() == 0);
    mf = (stk.size() == c_depth);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (p && q && !me) begin
      sb.push_back(stk[$]);
      stk[$] = d;
    end else if (p) begin
      if (mf) m_ovf = 1'b1;
      else stk.push_back(d);
      if (q) m_udf = 1'b1;
    end else if (q) begin
      if (me) m_udf = 1'b1;
      else sb.push_back(stk.pop_back());
    end else if (t) begin
      if (me) m_udf = 1'b1;
      else sb.push_back(stk[$]);
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
    if (sb.size() > 0) m_dout = sb.pop_front();
    chk("dout", 32'(dout), 32'(m_dout));
    chk_state();
  endtask

  initial begin
    logic [7:0] lifo [4];
    lifo = '{8'h44, 8'h33, 8'h22, 8'h11};
    clk = 1'b0; rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0;
    err_clr = 1'b0; din = '0;
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;

    // Reset pulse entirely before the first rising edge.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  32'(dout),  32'h00);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_udf",   32'(udf),   32'd0);
    cmd(0, 0, 0, 0, 8'h00);

    // Fill then overflow.
    cmd(1, 0, 0, 0, 8'h11);
    cmd(1, 0, 0, 0, 8'h22);
    cmd(1, 0, 0, 0, 8'h33);
    cmd(1, 0, 0, 0, 8'h44);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full",  32'(full),  32'd1);
    cmd(1, 0, 0, 0, 8'h55);
    chk("ovf_set",   32'(ovf),   32'd1);
    chk("ovf_count", 32'(count), 32'd4);

    // LIFO drain; the fifth pop carries err_clr to exercise set-over-clear.
    for (int i = 0; i < 4; i++) begin
      cmd(0, 1, 0, 0, 8'h00);
      chk("lifo_dout", 32'(dout), 32'(lifo[i]));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("prio_ovf_pre", 32'(ovf), 32'd1);
    cmd(0, 1, 0, 1, 8'h00);
    chk("udf_set",   32'(udf),  32'd1);
    chk("udf_hold",  32'(dout), 32'h11);
    chk("prio_ovf",  32'(ovf),  32'd0);
    cmd(0, 0, 0, 1, 8'h00);
    chk("clr_udf",   32'(udf),  32'd0);

    // Tos and replace.
    cmd(1, 0, 0, 0, 8'hA0);
    cmd(1, 0, 0, 0, 8'hB0);
    cmd(0, 0, 1, 0, 8'h00);
    chk("tos_dout",  32'(dout),  32'hB0);
    chk("tos_count", 32'(count), 32'd2);
    cmd(1, 1, 0, 0, 8'hC0);
    chk("rep_dout",  32'(dout),  32'hB0);
    chk("rep_count", 32'(count), 32'd2);
    cmd(0, 1, 0, 0, 8'h00);
    chk("rep_pop",   32'(dout),  32'hC0);
    chk("rep_cnt1",  32'(count), 32'd1);

    // Tos alongside push is ignored; push+pop on empty acts as push.
    cmd(1, 0, 1, 0, 8'hD1);
    cmd(0, 1, 0, 0, 8'h00);
    cmd(0, 1, 0, 0, 8'h00);
    cmd(1, 1, 0, 0, 8'hE2);
    cmd(0, 0, 0, 1, 8'h00);

    // Replace on a full stack.
    cmd(1, 0, 0, 0, 8'h01);
    cmd(1, 0, 0, 0, 8'h02);
    cmd(1, 0, 0, 0, 8'h03);
    cmd(1, 1, 0, 0, 8'h7F);
    chk("repfull_dout", 32'(dout), 32'h03);
    cmd(0, 0, 1, 0, 8'h00);
    chk("repfull_tos", 32'(dout), 32'h7F);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
          8'($urandom));
    end

    // Mid-operation asynchronous reset.
    cmd(0, 0, 0, 1, 8'h00);
    while (stk.size() > 0) cmd(0, 1, 0, 0, 8'h00);
    cmd(1, 0, 0, 0, 8'h5A);
    cmd(1, 0, 0, 0, 8'h6B);
    cmd(0, 0, 1, 0, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_dout",  32'(dout),  32'h00);
    chk("arst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    stk.delete(); sb.delete();
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    cmd(0, 1, 0, 0, 8'h00);
    chk("arst_udf", 32'(udf), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
